instruction_prefetch: RTL

Fetch front end feeding the instruction queue consumed by program_flow_control and the other execution units. Owns the sequential fetch address, issues 16-byte line reads to the memory access controller over a tx/rx port pair, and packs returned bytes into a circular byte buffer. Exposes the first 6 buffered bytes with their address. On `jmp`/`new_pc` from program_flow_control it flushes the buffer and redirects fetch.

---
 rtl/instruction_prefetch_if.sv | 24 ++
 rtl/instruction_prefetch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_if.sv
// Line-access request type and the tx/rx port pair between the fetch front end
// and the memory access controller.
package instruction_prefetch_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic         rqt;
        logic [15:0]  wmsk;
        logic [127:0] dat;
    } line_acc_req;
endpackage

interface instruction_prefetch_if;
    import instruction_prefetch_pkg::*;

    logic        tx_rp;
    line_acc_req tx_req;
    logic        tx_ra;
    logic        rx_rp;
    line_acc_req rx_req;
    logic        rx_ra;

    modport master (output tx_rp, tx_req, rx_ra, input tx_ra, rx_rp, rx_req);
    modport slave  (input tx_rp, tx_req, rx_ra, output tx_ra, rx_rp, rx_req);
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction fetch front end: issues 16-byte line reads, packs returned bytes
// into a circular buffer and presents the first six bytes with their address.
module instruction_prefetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jmp,
    input  logic [31:0]            new_pc,
    output logic [47:0]            q_dat,
    output logic [31:0]            q_addr,
    output logic [5:0]             q_cnt,
    input  logic                   q_pop,
    input  logic [2:0]             q_pop_len,
    instruction_prefetch_if.master mac_prt
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

    state_t          state, state_nxt;
    logic            tx_rp_r, tx_rp_nxt;
    logic [31:0]     tx_addr_r, tx_addr_nxt;
    logic            rx_ra_r, rx_ra_nxt;
    logic [31:0]     fetch_addr, fetch_nxt;
    logic            discard, discard_nxt;
    logic [31:0]     head_addr;
    logic [PW-1:0]   head_ptr, tail_ptr;
    logic [CW-1:0]   count;
    logic [7:0]      mem [BUF_BYTES];

    logic [4:0]      need;
    logic [CW-1:0]   free;
    logic [CW-1:0]   pop_req;
    logic [CW-1:0]   pop_n;
    logic [CW-1:0]   push_n;
    logic            pop_ok;
    logic            do_push;
    logic            unused_rx;

    assign need    = 5'd16 - {1'b0, fetch_addr[3:0]};
    assign free    = CW'(BUF_BYTES) - count;
    assign pop_ok  = q_pop && (q_pop_len != 3'd0) && (q_pop_len <= 3'd6);
    assign pop_req = CW'(q_pop_len);
    assign pop_n   = pop_ok ? ((pop_req < count) ? pop_req : count) : '0;
    // A redirect on the response edge drops the line just like a pending discard.
    assign do_push = (state == WAIT) && mac_prt.rx_rp && !discard && !jmp;
    assign push_n  = do_push ? CW'(need) : '0;

    assign unused_rx = ^{mac_prt.rx_req.addr, mac_prt.rx_req.rqt, mac_prt.rx_req.wmsk};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx_rp_r    <= 1'b0;
            tx_addr_r  <= '0;
            rx_ra_r    <= 1'b0;
            fetch_addr <= RESET_PC;
            discard    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_rp_r    <= tx_rp_nxt;
            tx_addr_r  <= tx_addr_nxt;
            rx_ra_r    <= rx_ra_nxt;
            fetch_addr <= fetch_nxt;
            discard    <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_rp_nxt   = tx_rp_r;
        tx_addr_nxt = tx_addr_r;
        rx_ra_nxt   = 1'b0;
        fetch_nxt   = fetch_addr;
        discard_nxt = discard;
        case (state)
            IDLE: begin
                // Skip issuing on a redirect edge so no stale line is ever requested.
                if (!jmp && (free >= CW'(need))) begin
                    tx_rp_nxt   = 1'b1;
                    tx_addr_nxt = {fetch_addr[31:4], 4'b0000};
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (jmp) discard_nxt = 1'b1;
                if (mac_prt.tx_ra) begin
                    tx_rp_nxt = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mac_prt.rx_rp) begin
                    rx_ra_nxt   = 1'b1;
                    discard_nxt = 1'b0;
                    state_nxt   = ACK;
                    // A discarded line must not advance past the redirect target.
                    if (!discard) fetch_nxt = {fetch_addr[31:4] + 28'd1, 4'b0000};
                end else if (jmp) begin
                    discard_nxt = 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (jmp) fetch_nxt = new_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_addr <= RESET_PC;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
        end else if (jmp) begin
            head_addr <= new_pc;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            count     <= '0;
        end else begin
            head_addr <= head_addr + 32'(pop_n);
            head_ptr  <= head_ptr + PW'(pop_n);
            tail_ptr  <= tail_ptr + PW'(push_n);
            count     <= count + push_n - pop_n;
        end
    end

    // Line bytes from the fetch offset upward land at tail in ascending order.
    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < 16; i++) begin
                if (5'(i) < need)
                    mem[tail_ptr + PW'(i)] <= mac_prt.rx_req.dat[{fetch_addr[3:0] + 4'(i), 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        q_dat = '0;
        for (int k = 0; k < 6; k++) begin
            if (CW'(k) < count) q_dat[8*k +: 8] = mem[head_ptr + PW'(k)];
        end
    end

    assign q_addr         = head_addr;
    assign q_cnt          = 6'(count);
    assign mac_prt.tx_rp  = tx_rp_r;
    assign mac_prt.rx_ra  = rx_ra_r;
    assign mac_prt.tx_req = '{addr: tx_addr_r, rqt: 1'b0, wmsk: 16'h0000, dat: 128'h0};
endmodule
